bluetooth: RTL and testbench
============================

BLUETOOTH -- requirements
Module: bluetooth

Interface
REQ-001 Parameter: BPS_NUM, default 10417, clock cycles per UART bit (100 MHz / 9600 baud); simulation benches use 5.
REQ-002 clk  input  1  system clock (100 MHz); all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low; rst=0 sampled at a rising edge resets the block.
REQ-004 in_msg  input  1  asynchronous UART serial line from the Bluetooth module; idle high.
REQ-005 speed  output  8  last correctly received byte (difficulty / move-speed code); registered.

Function
REQ-006 Frame format SHALL be 8N1: one low start bit, 8 data bits LSB first, one high stop bit, no parity.
REQ-007 in_msg SHALL pass through a 2-flop synchronizer before any use; both flops reset to 1.
REQ-008 Start detection SHALL be a falling edge of the synchronized line (previous sample 1, current sample 0) while in IDLE.
REQ-009 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-010 IDLE -> START on a detected falling edge; the bit counter clears to 0.
REQ-011 START: after BPS_NUM/2 cycles (integer division), sample the line; 1 -> false start, return to IDLE with no output change; 0 -> enter DATA with the bit counter cleared.
REQ-012 DATA: every BPS_NUM cycles sample one data bit (mid-bit) into the shift register, first sample = bit 0; after the 8th sample -> STOP.
REQ-013 STOP: after BPS_NUM cycles sample the stop bit; 1 -> speed loads the assembled byte on that same clock edge, go to IDLE; 0 -> framing error, discard the byte, speed unchanged, go to IDLE.
REQ-014 After a framing error, a new start SHALL be accepted only after the synchronized line has returned high and falls again (edge rule of REQ-008).
REQ-015 speed SHALL hold its value between frames and change only per REQ-013 or reset.
REQ-016 Latency: speed SHALL update no later than 2 + BPS_NUM/2 + 9*BPS_NUM + 2 cycles after the start-bit falling edge at the pin.
REQ-017 in_msg activity outside a frame, and while in START/DATA/STOP except at sample points, SHALL NOT affect state.
REQ-018 The cycle counter SHALL be wide enough to hold BPS_NUM-1 without overflow; it resets to 0 at every sample point.
REQ-019 Back-to-back frames (new start bit immediately after the stop bit) SHALL be received without loss.

Reset
REQ-020 While rst=0 at a clock edge: state=IDLE, counters=0, shift register=0x00, synchronizer flops=1, speed=8'h00.
REQ-021 Reset asserted mid-frame SHALL abort the frame; the partial byte SHALL never appear on speed.
REQ-022 If in_msg is low when rst releases, the first synchronized low SHALL count as a start edge (synchronizer reset value 1); the START check of REQ-011 filters it.

Verification (BPS_NUM=5, 2 ns clock period)
REQ-023 Hold rst=0 for 5 cycles with in_msg toggling -> speed=8'h00 throughout, FSM IDLE.
REQ-024 Release rst, send start (5 cycles low), data bits 1,0,0,1,0,1,0,1, stop high -> speed=8'hA9 within REQ-016 latency, held while idle.
REQ-025 Send back-to-back frames 8'h00 then 8'hFF -> speed=8'h00, then 8'hFF.
REQ-026 Pulse in_msg low for 2 cycles only -> false start, speed unchanged.
REQ-027 Send 8'h3C with stop bit low -> speed keeps prior value; a following valid 8'h55 frame -> speed=8'h55.
REQ-028 Assert rst mid-DATA, release, send 8'h81 -> speed=8'h00 after reset, then 8'h81.

Source files
------------

// File: rtl/bluetooth.sv
// UART receiver (8N1) for the Bluetooth link; the last good byte is held on speed.
// The line is double-synchronized and sampled mid-bit, timed from the start-bit edge.
module bluetooth #(
  parameter int unsigned BPS_NUM = 10417
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_msg,
  output logic [7:0] speed
);

  localparam int unsigned CW   = $clog2(BPS_NUM + 1);
  localparam int unsigned HALF = BPS_NUM / 2;
  localparam logic [CW-1:0] HALF_LAST = CW'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BPS_NUM - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic            sync1, sync2, line_prev;
  logic            fall;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [7:0]      shreg, shreg_n;
  logic [7:0]      speed_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      line_prev <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      speed     <= '0;
    end else begin
      sync1     <= in_msg;
      sync2     <= sync1;
      line_prev <= sync2;
      state     <= state_n;
      cnt       <= cnt_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      speed     <= speed_n;
    end
  end

  // A start needs the synchronized line to go high->low, so a line stuck low
  // after a framing error cannot retrigger reception.
  assign fall = line_prev & ~sync2;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    speed_n   = speed;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (fall) begin
          state_n   = START;
          bit_cnt_n = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (sync2) begin
            state_n = IDLE;
          end else begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          shreg_n   = {sync2, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (sync2) speed_n = shreg;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bluetooth.sv
// Directed bench for bluetooth: table of frames with expected speed, plus
// hand sequences for reset, false start, stop-edge timing and mid-frame reset.
module tb_bluetooth;

  localparam int unsigned BPS = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_msg;
  logic [7:0] speed;

  int checks = 0;
  int errors = 0;

  bluetooth #(.BPS_NUM(BPS)) dut (
    .clk   (clk),
    .rst   (rst),
    .in_msg(in_msg),
    .speed (speed)
  );

  always #1 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic [7:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: speed=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic hold_bit(input logic b, input int n);
    in_msg = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] d, input int nbits);
    hold_bit(1'b0, BPS);
    for (int i = 0; i < nbits; i++) hold_bit(d[i], BPS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bits(d, 8);
    hold_bit(stop, BPS);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'hA9, 1'b1, 10, 8'hA9};
    vecs[1] = '{8'h00, 1'b1,  4, 8'h00};
    vecs[2] = '{8'hFF, 1'b1,  0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b0,  0, 8'hFF};
    vecs[4] = '{8'h55, 1'b1,  3, 8'h55};
    vecs[5] = '{8'h01, 1'b1,  0, 8'h01};
    vecs[6] = '{8'h80, 1'b1,  0, 8'h80};

    // reset held with line activity
    rst = 1'b0;
    in_msg = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      in_msg = ~in_msg;
      @(negedge clk);
      check("reset_hold", speed, 8'h00);
    end
    in_msg = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("after_release", speed, 8'h00);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].gap > 0) hold_bit(1'b1, vecs[i].gap);
      send_frame(vecs[i].data, vecs[i].stop);
      check($sformatf("frame%0d", i), speed, vecs[i].exp);
    end

    hold_bit(1'b1, 30);
    check("idle_hold", speed, 8'h80);

    // 2-cycle glitch is rejected by the mid-start check
    hold_bit(1'b0, 2);
    hold_bit(1'b1, 30);
    check("false_start", speed, 8'h80);

    // speed must not move before the stop bit's sample point
    send_bits(8'h5A, 8);
    check("before_stop", speed, 8'h80);
    hold_bit(1'b1, 2);
    check("early_stop", speed, 8'h80);
    hold_bit(1'b1, 3);
    check("stop_load", speed, 8'h5A);
    hold_bit(1'b1, 10);

    // reset in the middle of DATA drops the partial byte
    send_bits(8'h81, 3);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_reset", speed, 8'h00);
    in_msg = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    hold_bit(1'b1, 20);
    check("post_reset_idle", speed, 8'h00);
    send_frame(8'h81, 1'b1);
    check("post_reset_frame", speed, 8'h81);

    // framing error, line left low: no retrigger until it goes high again
    hold_bit(1'b1, 5);
    send_frame(8'hC3, 1'b0);
    hold_bit(1'b0, 40);
    check("stuck_low", speed, 8'h81);
    hold_bit(1'b1, 5);
    send_frame(8'h6E, 1'b1);
    check("recover", speed, 8'h6E);
    hold_bit(1'b1, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: speed=%h expected=finish", speed);
    $fatal(1, "timeout");
  end

endmodule
